// File: rtl/maze_pkg.sv
// Shared maze geometry, wall-index helpers and build-state encoding.
// Used by the build controller, the wall store and the renderer.
package maze_pkg;

  function automatic int idx_width(int cols, int rows);
    int h;
    int v;
    h = cols * (rows + 1);
    v = (cols + 1) * rows;
    return $clog2((h > v) ? h : v);
  endfunction

  localparam int COLS    = 16;
  localparam int ROWS    = 10;
  localparam int H_WALLS = COLS * (ROWS + 1);
  localparam int V_WALLS = (COLS + 1) * ROWS;
  localparam int IDX_W   = idx_width(COLS, ROWS);

  // Horizontal wall above cell (r,c); r runs 0..rows so the bottom border is row 'rows'.
  function automatic int h_idx(int r, int c, int cols);
    return r * cols + c;
  endfunction

  // Vertical wall left of cell (r,c); c runs 0..cols so the right border is column 'cols'.
  function automatic int v_idx(int r, int c, int cols);
    return r * (cols + 1) + c;
  endfunction

  typedef logic [2:0] build_state_t;
  localparam build_state_t ST_IDLE      = 3'd0;
  localparam build_state_t ST_FILL_H    = 3'd1;
  localparam build_state_t ST_FILL_V    = 3'd2;
  localparam build_state_t ST_CARVE_TOP = 3'd3;
  localparam build_state_t ST_CARVE     = 3'd4;
  localparam build_state_t ST_DONE      = 3'd5;

endpackage

// File: rtl/maze_range_pick.sv
// Scales a 7-bit random fraction onto 0..run_len-1: (rnd_hi * run_len) >> 7.
module maze_range_pick (
  input  logic [6:0] rnd_hi,
  input  logic [7:0] run_len,
  output logic [7:0] offset
);

  logic [14:0] product;

  assign product = {8'd0, rnd_hi} * {7'd0, run_len};
  assign offset  = product[14:7];

endmodule

// File: rtl/maze_build_ctrl.sv
// Maze build sequencer: fills all walls, then carves a sidewinder maze,
// issuing exactly one wall write per cycle through a single write port.
module maze_build_ctrl #(
  parameter int COLS  = maze_pkg::COLS,
  parameter int ROWS  = maze_pkg::ROWS,
  parameter int IDX_W = maze_pkg::idx_width(COLS, ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       rnd,
  output logic             wr_en,
  output logic             wr_sel,
  output logic [IDX_W-1:0] wr_index,
  output logic             wr_data,
  output logic             busy,
  output logic             done
);
  import maze_pkg::*;

  localparam int H_CNT = COLS * (ROWS + 1);
  localparam int V_CNT = (COLS + 1) * ROWS;
  localparam int RW    = $clog2(ROWS);

  build_state_t     state;
  logic [IDX_W-1:0] fill_idx;
  logic [RW-1:0]    row;
  logic [7:0]       col;
  logic [7:0]       run_start;

  logic             close;
  logic [7:0]       run_len;
  logic [7:0]       offset;
  logic [7:0]       k;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    close   = (col == 8'(COLS - 1)) | rnd[0];
    run_len = col - run_start + 8'd1;
    k       = run_start + offset;
  end

  maze_range_pick u_pick (
    .rnd_hi  (rnd[7:1]),
    .run_len (run_len),
    .offset  (offset)
  );

  // NOTE: state and outputs use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fill_idx  <= '0;
      row       <= '0;
      col       <= '0;
      run_start <= '0;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_index  <= '0;
      wr_data   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          // First cycle in DONE still shows busy from the last write; retire it as the done pulse.
          if (state == ST_DONE && busy) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else if (start) begin
            state    <= ST_FILL_H;
            busy     <= 1'b1;
            wr_en    <= 1'b1;
            wr_sel   <= 1'b0;
            wr_index <= '0;
            wr_data  <= 1'b1;
            fill_idx <= IDX_W'(1);
          end
        end

        ST_FILL_H: begin
          wr_en    <= 1'b1;
          wr_sel   <= 1'b0;
          wr_index <= fill_idx;
          wr_data  <= 1'b1;
          if (fill_idx == IDX_W'(H_CNT - 1)) begin
            state    <= ST_FILL_V;
            fill_idx <= '0;
          end else begin
            fill_idx <= fill_idx + IDX_W'(1);
          end
        end

        ST_FILL_V: begin
          wr_en    <= 1'b1;
          wr_sel   <= 1'b1;
          wr_index <= fill_idx;
          wr_data  <= 1'b1;
          if (fill_idx == IDX_W'(V_CNT - 1)) begin
            state <= ST_CARVE_TOP;
            col   <= '0;
          end else begin
            fill_idx <= fill_idx + IDX_W'(1);
          end
        end

        ST_CARVE_TOP: begin
          wr_en    <= 1'b1;
          wr_sel   <= 1'b1;
          wr_index <= IDX_W'(v_idx(0, int'(col) + 1, COLS));
          wr_data  <= 1'b0;
          if (col == 8'(COLS - 2)) begin
            state     <= ST_CARVE;
            row       <= RW'(1);
            col       <= '0;
            run_start <= '0;
          end else begin
            col <= col + 8'd1;
          end
        end

        ST_CARVE: begin
          wr_en   <= 1'b1;
          wr_data <= 1'b0;
          if (close) begin
            wr_sel    <= 1'b0;
            wr_index  <= IDX_W'(h_idx(int'(row), int'(k), COLS));
            run_start <= col + 8'd1;
          end else begin
            wr_sel   <= 1'b1;
            wr_index <= IDX_W'(v_idx(int'(row), int'(col) + 1, COLS));
          end
          if (col == 8'(COLS - 1)) begin
            col       <= '0;
            run_start <= '0;
            if (row == RW'(ROWS - 1)) state <= ST_DONE;
            else                      row   <= row + RW'(1);
          end else begin
            col <= col + 8'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_build_ctrl.sv
// Directed bench for maze_build_ctrl at COLS=4, ROWS=3 with a wall-store model.
module tb_maze_build_ctrl;

  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int IDX_W = 4;
  localparam int N     = 42;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       rnd;
  logic             wr_en;
  logic             wr_sel;
  logic [IDX_W-1:0] wr_index;
  logic             wr_data;
  logic             busy;
  logic             done;

  logic [15:0] hw;
  logic [14:0] vw;
  int n_total = 0;
  int n_bad   = 0;

  maze_build_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rnd      (rnd),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_index (wr_index),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic borders_ok();
    return (hw[3:0] == 4'hF) && (hw[15:12] == 4'hF) &&
           vw[0] && vw[5] && vw[10] && vw[4] && vw[9] && vw[14];
  endfunction

  // Called just after a negedge. mode 0: rnd=0x00, 1: rnd=0xFF, 2: random each cycle.
  // repulse_at >= 0 raises start again on that busy cycle.
  task automatic do_build(input int mode, input int repulse_at);
    int busy_cnt;
    int wr_cnt;
    logic got_done;
    hw = '0;
    vw = '0;
    busy_cnt = 0;
    wr_cnt   = 0;
    got_done = 1'b0;
    rnd = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_write", {25'd0, wr_en, wr_sel, wr_index, wr_data}, 32'h41);
    for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
      if (done) begin
        got_done = 1'b1;
        check("done_wr_en", 32'(wr_en), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
      end else begin
        if (busy) busy_cnt++;
        if (wr_en) begin
          wr_cnt++;
          if (wr_sel) vw[wr_index] = wr_data;
          else        hw[wr_index] = wr_data;
        end
        start = (cyc == repulse_at);
        if (mode == 2) rnd = 8'($urandom);
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(N));
    check("write_count", 32'(wr_cnt), 32'(N));
  endtask

  initial begin
    int quiet;
    rst   = 1'b1;
    start = 1'b0;
    rnd   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {25'd0, wr_en, wr_sel, wr_index, wr_data}, 32'd0);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_quiet", {23'd0, wr_en, wr_sel, wr_index, wr_data, busy, done}, 32'd0);

    // rnd 0x00: every run spans the row and carves north at column 0.
    do_build(0, -1);
    check("r00_h", 32'(hw), 32'hFEEF);
    check("r00_v", 32'(vw), 32'h4631);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    // rnd 0xFF: every cell closes alone; k stays at c.
    do_build(1, -1);
    check("rff_h", 32'(hw), 32'hF00F);
    check("rff_v", 32'(vw), 32'h7FF1);

    // Rebuild started on the done cycle itself (DONE state accepts start).
    do_build(0, -1);
    do_build(1, -1);
    check("rebuild_h", 32'(hw), 32'hF00F);
    check("rebuild_v", 32'(vw), 32'h7FF1);

    // Reset in the middle of FILL_V.
    rnd   = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("in_fill_v", {31'd0, wr_sel}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    quiet = 0;
    for (int i = 0; i < 50; i++) begin
      if (wr_en || busy || done) quiet++;
      @(negedge clk);
    end
    check("post_rst_quiet", 32'(quiet), 32'd0);
    do_build(0, -1);
    check("post_rst_h", 32'(hw), 32'hFEEF);
    check("post_rst_v", 32'(vw), 32'h4631);

    // start re-pulsed while carving must not disturb the build.
    do_build(0, 35);
    check("repulse_h", 32'(hw), 32'hFEEF);
    check("repulse_v", 32'(vw), 32'h4631);

    // Random builds: borders intact and exactly COLS*ROWS-1 walls removed.
    for (int b = 0; b < 1000; b++) begin
      do_build(2, -1);
      check("rand_borders", 32'(borders_ok()), 32'd1);
      check("rand_cleared", 32'(31 - $countones({hw, vw})), 32'(COLS * ROWS - 1));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
